// File: rtl/otp_cipher_pkg.sv
// Shared definitions for the one-time-pad byte cipher: default key width,
// controller state encoding and key-size helpers.
`ifndef TEXT_SIZE_2
`define TEXT_SIZE_2 64
`endif

package otp_cipher_pkg;

   localparam int BYTES_PER_KEY = `TEXT_SIZE_2 / 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_RUN    = 3'd2,
      ST_REFILL = 3'd3,
      ST_DRAIN  = 3'd4
   } state_e;

   function automatic int bytes_per_key(input int key_w);
      return key_w / 8;
   endfunction

endpackage

// File: rtl/otp_cipher_byte_sel.sv
// otp_byte_sel: picks key byte idx_i out of the latched key word.
import otp_cipher_pkg::*;

module otp_byte_sel #(
   parameter int N_BYTES = BYTES_PER_KEY,
   parameter int IDX_W   = $clog2(N_BYTES)
) (
   input  logic [8*N_BYTES-1:0] key_i,
   input  logic [IDX_W-1:0]     idx_i,
   output logic [7:0]           byte_o
);

   // Plain mux over the valid byte lanes; out-of-range indices read zero.
   always_comb begin
      byte_o = 8'h00;
      for (int b = 0; b < N_BYTES; b++) begin
         if (idx_i == IDX_W'(b)) byte_o = key_i[8*b +: 8];
      end
   end

endmodule

// File: rtl/otp_cipher.sv
// otp_cipher: XORs a plaintext byte stream with successive bytes of a key
// word supplied by an external shifter, requesting a fresh key word when the
// current one is used up or the message ends, so key bytes are never reused.
// Optional build macro: OTP_CIPHER_COUNT_EN adds the msg_len byte counter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_LATCH  | capture key_in, clear byte index
// ST_RUN    | accept plaintext bytes, emit ciphertext one cycle later
// ST_REFILL | key exhausted mid-message, key_adv pulse in flight
// ST_DRAIN  | last byte accepted, waiting for it to leave, then done
`ifndef TEXT_SIZE_2
`define TEXT_SIZE_2 64
`endif

module otp_cipher
   import otp_cipher_pkg::*;
#(
   parameter int KEY_W = `TEXT_SIZE_2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [KEY_W-1:0] key_in,
   output logic             key_adv,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_last,
   input  logic             out_ready,
`ifdef OTP_CIPHER_COUNT_EN
   output logic [15:0]      msg_len,
`endif
   output logic             busy,
   output logic             done
);

   localparam int BPK   = bytes_per_key(KEY_W);
   localparam int IDX_W = $clog2(BPK);

   state_e             state_q;
   logic [KEY_W-1:0]   key_buf_q;
   logic [IDX_W-1:0]   idx_q;
   logic               out_valid_q;
   logic [7:0]         out_data_q;
   logic               out_last_q;
   logic               key_adv_q;
   logic               done_q;

   logic [7:0]         key_byte;
   logic [7:0]         out_data_d;
   logic               accept;
   logic               key_end;

   otp_byte_sel #(
      .N_BYTES (BPK),
      .IDX_W   (IDX_W)
   ) u_byte_sel (
      .key_i  (key_buf_q),
      .idx_i  (idx_q),
      .byte_o (key_byte)
   );

   // The output register may only be refilled when it is empty or emptying.
   assign in_ready   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready;
   assign key_end    = (idx_q == IDX_W'(BPK - 1));
   assign out_data_d = in_data ^ key_byte;

   // Controller, byte index, key buffer and registered stream outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         key_buf_q   <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_last_q  <= 1'b0;
         key_adv_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         key_adv_q <= 1'b0;
         done_q    <= 1'b0;

         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_last_q  <= in_last;
            idx_q       <= idx_q + IDX_W'(1);
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) state_q <= ST_LATCH;
            end
            ST_LATCH: begin
               key_buf_q <= key_in;
               idx_q     <= '0;
               state_q   <= ST_RUN;
            end
            ST_RUN: begin
               // End of message wins over end of key: one key_adv covers both.
               if (accept && in_last) begin
                  key_adv_q <= 1'b1;
                  state_q   <= ST_DRAIN;
               end else if (accept && key_end) begin
                  key_adv_q <= 1'b1;
                  state_q   <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               state_q <= ST_LATCH;
            end
            ST_DRAIN: begin
               if (!out_valid_q || out_ready) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef OTP_CIPHER_COUNT_EN
   logic [15:0] msg_len_q;

   // Bytes accepted in the current message; restarts on start, sticks at max.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         msg_len_q <= 16'h0000;
      end else if ((state_q == ST_IDLE) && start) begin
         msg_len_q <= 16'h0000;
      end else if (accept && (msg_len_q != 16'hFFFF)) begin
         msg_len_q <= msg_len_q + 16'd1;
      end
   end

   assign msg_len = msg_len_q;
`endif

   assign key_adv   = key_adv_q;
   assign done      = done_q;
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_otp_cipher.sv
// Directed bench for otp_cipher with KEY_W=64 and a model key shifter that
// steps through a fixed table of key words on every key_adv pulse.
module tb_otp_cipher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [63:0] key_in;
   logic        key_adv;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        done;
`ifdef OTP_CIPHER_COUNT_EN
   logic [15:0] msg_len;
`endif

   int n_vec = 0;
   int n_err = 0;
   int key_sel = 0;
   int adv_cnt = 0;
   int done_cnt = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   otp_cipher #(.KEY_W(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .key_in    (key_in),
      .key_adv   (key_adv),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
`ifdef OTP_CIPHER_COUNT_EN
      .msg_len   (msg_len),
`endif
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] key_of(input int k);
      case (k)
         0:       return 64'h0807060504030201;
         1:       return 64'hA7A6A5A4A3A2A1A0;
         2:       return 64'h8877665544332211;
         3:       return 64'h0000000000005AA5;
         4:       return 64'h0123456789ABCDEF;
         5:       return 64'h000000000000C33C;
         default: return 64'h1020304050607080;
      endcase
   endfunction

   assign key_in = key_of(key_sel);

   always @(posedge clk) begin
      if (key_adv) key_sel <= key_sel + 1;
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) got_q.push_back(out_data);
         if (key_adv) adv_cnt <= adv_cnt + 1;
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l, output int st);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      st = 0;
      @(negedge clk);
      while (!in_ready && st < 40) begin
         st++;
         @(negedge clk);
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int   n = 0;
      logic prev_hs = 1'b0;
      @(negedge clk);
      while (!done && n < 60) begin
         prev_hs = out_valid && out_ready && out_last;
         n++;
         @(negedge clk);
      end
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_done_lat"}, prev_hs, 1'b1);
      chk({tag, "_idle"}, busy, 1'b0);
      #1;
   endtask

   task automatic check_out(input string tag, input int base);
      chk({tag, "_nbytes"}, 64'(got_q.size() - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < got_q.size())
            chk($sformatf("%s_b%0d", tag, i), got_q[base + i], exp_q[i]);
      end
      exp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int b_out;
      int b_adv;
      int b_done;
      int stalls [10];

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_key_adv", key_adv, 1'b0);
      chk("rst_done", done, 1'b0);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;

      // Short message, single key word, continuous drain
      out_ready = 1'b1;
      b_out = got_q.size(); b_adv = adv_cnt; b_done = done_cnt;
      pulse_start();
      chk("t2_busy", busy, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'(i), (i == 3), st);
      wait_done("t2");
      exp_q = '{8'h01, 8'h03, 8'h01, 8'h07};
      check_out("t2", b_out);
      chk("t2_adv", 64'(adv_cnt - b_adv), 1);
      chk("t2_ndone", 64'(done_cnt - b_done), 1);

      // Downstream stall: output holds, input blocked, nothing lost
      @(posedge clk); #1;
      out_ready = 1'b0;
      b_out = got_q.size(); b_adv = adv_cnt;
      pulse_start();
      send_byte(8'h10, 1'b0, st);
      chk("t3_lat_valid", out_valid, 1'b1);
      chk("t3_lat_data", out_data, 8'hB0);
      in_valid = 1'b1; in_data = 8'h21; in_last = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t3_hold_rdy%0d", k), in_ready, 1'b0);
         chk($sformatf("t3_hold_data%0d", k), out_data, 8'hB0);
         chk($sformatf("t3_hold_valid%0d", k), out_valid, 1'b1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      send_byte(8'h21, 1'b0, st);
      send_byte(8'h32, 1'b1, st);
      wait_done("t3");
      exp_q = '{8'hB0, 8'h80, 8'h90};
      check_out("t3", b_out);
      chk("t3_adv", 64'(adv_cnt - b_adv), 1);

      // Ten bytes: key refill after byte 8, second key word for bytes 9-10
      @(posedge clk); #1;
      b_out = got_q.size(); b_adv = adv_cnt;
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         send_byte(8'(i), (i == 9), st);
         stalls[i] = st;
      end
      wait_done("t4");
      exp_q = '{8'h11, 8'h23, 8'h31, 8'h47, 8'h51, 8'h63, 8'h71, 8'h8F, 8'hAD, 8'h53};
      check_out("t4", b_out);
      chk("t4_adv", 64'(adv_cnt - b_adv), 2);
      chk("t4_bubble", 64'(stalls[8]), 2);
      chk("t4_no_bubble", 64'(stalls[7]), 0);

      // Last byte on the final key byte: a single key_adv
      @(posedge clk); #1;
      b_out = got_q.size(); b_adv = adv_cnt; b_done = done_cnt;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         send_byte(8'hFF, (i == 7), st);
         stalls[i] = st;
      end
      wait_done("t5");
      exp_q = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
      check_out("t5", b_out);
      chk("t5_adv", 64'(adv_cnt - b_adv), 1);
      chk("t5_ndone", 64'(done_cnt - b_done), 1);

      // Reset mid-message, then a fresh message re-latches key_in
      @(posedge clk); #1;
      out_ready = 1'b0;
      b_done = done_cnt;
      pulse_start();
      send_byte(8'h55, 1'b0, st);
      chk("t6_pre_valid", out_valid, 1'b1);
      chk("t6_pre_busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_data", out_data, 8'h00);
      chk("t6_rst_inrdy", in_ready, 1'b0);
      chk("t6_rst_adv", key_adv, 1'b0);
      @(negedge clk);
      #2 reset = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      b_out = got_q.size();
      pulse_start();
      send_byte(8'h01, 1'b0, st);
      send_byte(8'h02, 1'b1, st);
      wait_done("t6");
      exp_q = '{8'h3D, 8'hC1};
      check_out("t6", b_out);
      chk("t6_ndone", 64'(done_cnt - b_done), 1);

`ifdef OTP_CIPHER_COUNT_EN
      // Byte counter: value after done, holds, clears on next start
      @(posedge clk); #1;
      pulse_start();
      for (int i = 0; i < 5; i++) send_byte(8'(i), (i == 4), st);
      wait_done("t7");
      chk("t7_len", msg_len, 16'd5);
      @(posedge clk); @(posedge clk); #1;
      chk("t7_len_hold", msg_len, 16'd5);
      pulse_start();
      chk("t7_len_clr", msg_len, 16'd0);
      send_byte(8'hAA, 1'b1, st);
      wait_done("t7b");
      chk("t7b_len", msg_len, 16'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
